// File: rtl/instr_loader.sv
// Keypad-driven instruction loader: commits entered words into instruction memory
// while holding the processor in reset, then releases it on submit.
module instr_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [31:0]       data,
    input  logic              did_change,
    input  logic              enter,
    input  logic              submit,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              cpu_reset,
    output logic              cpu_run,
    output logic              full,
    output logic              overflow
);

    typedef enum logic [1:0] {StLoad, StWrite, StRun} state_e;

    state_e            r_state, w_state_next;
    logic [31:0]       r_shadow, w_shadow_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [ADDR_W:0]   r_count, w_count_next;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [31:0]       r_mem_data, w_mem_data_next;
    logic              r_ovf, w_ovf_next;
    logic              r_pend, w_pend_next;
    logic              r_enter_d, r_submit_d;
    logic              w_enter_edge, w_submit_edge, w_full;

    assign w_enter_edge  = enter & ~r_enter_d;
    assign w_submit_edge = submit & ~r_submit_d;
    assign w_full        = r_count[ADDR_W];

    always_comb begin
        w_state_next    = r_state;
        w_shadow_next   = r_shadow;
        w_addr_next     = r_addr;
        w_count_next    = r_count;
        w_mem_addr_next = r_mem_addr;
        w_mem_data_next = r_mem_data;
        w_ovf_next      = r_ovf;
        w_pend_next     = r_pend;
        unique case (r_state)
            StLoad: begin
                if (did_change) w_shadow_next = data;
                if (w_enter_edge && !w_full) begin
                    // Bypass the shadow so a keystroke in the commit cycle is not lost
                    w_state_next    = StWrite;
                    w_mem_addr_next = r_addr;
                    w_mem_data_next = did_change ? data : r_shadow;
                    w_pend_next     = w_submit_edge;
                end else begin
                    if (w_enter_edge) w_ovf_next = 1'b1;
                    if (w_submit_edge && (r_count != '0)) w_state_next = StRun;
                end
            end
            StWrite: begin
                w_addr_next   = r_addr + 1'b1;
                w_count_next  = r_count + 1'b1;
                w_shadow_next = did_change ? data : 32'h0;
                w_pend_next   = 1'b0;
                // word_count is non-zero after this write, so a pending submit always runs
                w_state_next  = (r_pend || w_submit_edge) ? StRun : StLoad;
            end
            StRun: begin
                if (w_submit_edge) begin
                    w_state_next  = StLoad;
                    w_addr_next   = '0;
                    w_count_next  = '0;
                    w_shadow_next = 32'h0;
                    w_ovf_next    = 1'b0;
                    w_pend_next   = 1'b0;
                end
            end
            default: w_state_next = StLoad;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= StLoad;
            r_shadow   <= 32'h0;
            r_addr     <= '0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= 32'h0;
            r_ovf      <= 1'b0;
            r_pend     <= 1'b0;
            r_enter_d  <= 1'b0;
            r_submit_d <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shadow   <= w_shadow_next;
            r_addr     <= w_addr_next;
            r_count    <= w_count_next;
            r_mem_addr <= w_mem_addr_next;
            r_mem_data <= w_mem_data_next;
            r_ovf      <= w_ovf_next;
            r_pend     <= w_pend_next;
            r_enter_d  <= enter;
            r_submit_d <= submit;
        end
    end

    // Reset gates the strobe combinationally so a write caught by reset never reaches memory
    assign mem_wr_en   = (r_state == StWrite) && !reset;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_data;
    assign word_count  = r_count;
    assign cpu_reset   = (r_state != StRun);
    assign cpu_run     = ~cpu_reset;
    assign full        = w_full;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader, built with a four-word memory.
module tb_instr_loader;

    localparam int unsigned AW = 2;

    logic          clk;
    logic          reset;
    logic [31:0]   data;
    logic          did_change;
    logic          enter;
    logic          submit;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data;
    logic [AW:0]   word_count;
    logic          cpu_reset;
    logic          cpu_run;
    logic          full;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    instr_loader #(.ADDR_W(AW)) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .data        (data),
        .did_change  (did_change),
        .enter       (enter),
        .submit      (submit),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .word_count  (word_count),
        .cpu_reset   (cpu_reset),
        .cpu_run     (cpu_run),
        .full        (full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Key in a word, commit it with a one-cycle enter pulse, check the strobe
    task automatic commit(input logic [31:0] w, input logic [AW-1:0] a);
        data = w;
        did_change = 1'b1;
        tick();
        data = 32'h0;
        did_change = 1'b0;
        enter = 1'b1;
        tick();
        chk("commit_wr_en", 64'(mem_wr_en), 64'd1);
        chk("commit_addr", 64'(mem_addr), 64'(a));
        chk("commit_data", 64'(mem_wr_data), 64'(w));
        enter = 1'b0;
        tick();
        chk("commit_wr_en_low", 64'(mem_wr_en), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        data = 32'h0;
        did_change = 1'b0;
        enter = 1'b0;
        submit = 1'b0;
        tick();
        tick();
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_data", 64'(mem_wr_data), 64'd0);
        chk("rst_count", 64'(word_count), 64'd0);
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_cpu_run", 64'(cpu_run), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;

        // Digits then commit; data cleared alongside enter, enter held high as a level
        data = 32'h2408000A;
        did_change = 1'b1;
        tick();
        data = 32'h0;
        did_change = 1'b0;
        enter = 1'b1;
        tick();
        chk("t1_wr_en", 64'(mem_wr_en), 64'd1);
        chk("t1_addr", 64'(mem_addr), 64'd0);
        chk("t1_data", 64'(mem_wr_data), 64'h2408000A);
        tick();
        chk("t1_wr_en_low", 64'(mem_wr_en), 64'd0);
        chk("t1_count", 64'(word_count), 64'd1);
        tick();
        chk("t1_level_no_rewrite", 64'(mem_wr_en), 64'd0);
        chk("t1_level_count", 64'(word_count), 64'd1);
        chk("t1_data_hold", 64'(mem_wr_data), 64'h2408000A);
        enter = 1'b0;
        tick();

        // did_change and enter together: new data bypasses the shadow
        data = 32'h55AA_1234;
        did_change = 1'b1;
        enter = 1'b1;
        tick();
        chk("byp_wr_en", 64'(mem_wr_en), 64'd1);
        chk("byp_addr", 64'(mem_addr), 64'd1);
        chk("byp_data", 64'(mem_wr_data), 64'h55AA_1234);
        data = 32'h0;
        did_change = 1'b0;
        enter = 1'b0;
        tick();
        chk("byp_count", 64'(word_count), 64'd2);

        // Three commits then submit
        do_reset();
        commit(32'h1, 2'd0);
        commit(32'h2, 2'd1);
        commit(32'h3, 2'd2);
        chk("t2_count", 64'(word_count), 64'd3);
        chk("t2_cpu_reset_pre", 64'(cpu_reset), 64'd1);
        submit = 1'b1;
        tick();
        chk("t2_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("t2_cpu_run", 64'(cpu_run), 64'd1);
        submit = 1'b0;
        tick();

        // Fill the four-word memory, then an overflowing enter
        do_reset();
        commit(32'h10, 2'd0);
        commit(32'h11, 2'd1);
        commit(32'h12, 2'd2);
        chk("fill_full_pre", 64'(full), 64'd0);
        commit(32'h13, 2'd3);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(word_count), 64'd4);
        data = 32'h14;
        did_change = 1'b1;
        tick();
        data = 32'h0;
        did_change = 1'b0;
        enter = 1'b1;
        tick();
        chk("ovf_no_strobe", 64'(mem_wr_en), 64'd0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        enter = 1'b0;
        tick();
        chk("ovf_still_no_strobe", 64'(mem_wr_en), 64'd0);
        chk("ovf_count", 64'(word_count), 64'd4);
        submit = 1'b1;
        tick();
        chk("fill_run", 64'(cpu_run), 64'd1);
        submit = 1'b0;
        tick();

        // Submit from RUN restarts loading at address 0
        submit = 1'b1;
        tick();
        chk("reload_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("reload_count", 64'(word_count), 64'd0);
        chk("reload_full", 64'(full), 64'd0);
        chk("reload_overflow", 64'(overflow), 64'd0);
        submit = 1'b0;
        tick();
        commit(32'hDEADBEEF, 2'd0);
        chk("reload_count1", 64'(word_count), 64'd1);
        chk("reload_overflow1", 64'(overflow), 64'd0);

        // Submit with nothing loaded is ignored
        do_reset();
        submit = 1'b1;
        tick();
        chk("empty_submit_cpu_reset", 64'(cpu_reset), 64'd1);
        submit = 1'b0;
        tick();
        chk("empty_submit_still_load", 64'(cpu_run), 64'd0);

        // Coincident enter and submit: write first, run the cycle after WRITE
        data = 32'h77;
        did_change = 1'b1;
        tick();
        data = 32'h0;
        did_change = 1'b0;
        enter = 1'b1;
        submit = 1'b1;
        tick();
        chk("coin_wr_en", 64'(mem_wr_en), 64'd1);
        chk("coin_data", 64'(mem_wr_data), 64'h77);
        chk("coin_not_run_yet", 64'(cpu_run), 64'd0);
        enter = 1'b0;
        submit = 1'b0;
        tick();
        chk("coin_run", 64'(cpu_run), 64'd1);
        chk("coin_wr_en_low", 64'(mem_wr_en), 64'd0);
        chk("coin_count", 64'(word_count), 64'd1);

        // Reset during WRITE suppresses the strobe
        do_reset();
        data = 32'hCAFE_F00D;
        did_change = 1'b1;
        tick();
        data = 32'h0;
        did_change = 1'b0;
        enter = 1'b1;
        tick();
        chk("rw_wr_en", 64'(mem_wr_en), 64'd1);
        reset = 1'b1;
        #1;
        chk("rw_suppressed", 64'(mem_wr_en), 64'd0);
        tick();
        chk("rw_addr", 64'(mem_addr), 64'd0);
        chk("rw_data", 64'(mem_wr_data), 64'd0);
        chk("rw_count", 64'(word_count), 64'd0);
        chk("rw_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rw_wr_en_after", 64'(mem_wr_en), 64'd0);

        // enter already high at reset release counts as one event
        reset = 1'b0;
        tick();
        chk("rel_wr_en", 64'(mem_wr_en), 64'd1);
        chk("rel_addr", 64'(mem_addr), 64'd0);
        tick();
        chk("rel_count", 64'(word_count), 64'd1);
        chk("rel_single", 64'(mem_wr_en), 64'd0);
        enter = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets the instruction-memory word-address width; capacity is 2^ADDR_W words.
REQ-002 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 data  in  32  hex-entry word from the keypad entry stage.
REQ-005 did_change  in  1  high for a cycle in which data was updated by a digit keystroke.
REQ-006 enter  in  1  commit request from the entry stage (Enter key).
REQ-007 submit  in  1  program-complete / re-program request from the entry stage (Esc key).
REQ-008 mem_wr_en  out  1  instruction-memory write strobe, one cycle per committed word.
REQ-009 mem_addr  out  ADDR_W  word address for the write.
REQ-010 mem_wr_data  out  32  word written.
REQ-011 word_count  out  ADDR_W+1  number of words committed since the last load start.
REQ-012 cpu_reset  out  1  processor hold-in-reset; high while loading.
REQ-013 cpu_run  out  1  processor released; always equal to ~cpu_reset.
REQ-014 full  out  1  word_count equals 2^ADDR_W.
REQ-015 overflow  out  1  sticky flag; an enter was dropped because memory was full.

Function
REQ-016 The entry stage clears data in the same cycle it raises enter or submit. The block therefore SHALL hold a 32-bit shadow word, loaded from data in every cycle did_change is high, and SHALL commit the shadow word, never data sampled at enter.
REQ-017 enter and submit SHALL be rising-edge detected against a one-cycle delayed copy; a level held high counts as one event.
REQ-018 The state machine SHALL have three states: LOAD, WRITE and RUN.
REQ-019 In LOAD, an enter edge with full low SHALL move the block to WRITE.
- In the next cycle: mem_wr_en=1, mem_addr=current address, mem_wr_data=shadow.
- Latency is one cycle from the sampled edge to the strobe.
REQ-020 WRITE SHALL last exactly one cycle.
- On exit: address increments, word_count increments, shadow clears to 0, state returns to LOAD.
REQ-021 mem_wr_en SHALL be high only in WRITE; mem_addr and mem_wr_data are don't-care elsewhere but SHALL hold their last values.
REQ-022 In LOAD, an enter edge with full high SHALL produce no write and SHALL set overflow.
REQ-023 Address wrap: after the write to address 2^ADDR_W-1, the address wraps to 0, word_count reaches 2^ADDR_W and full asserts; no further writes occur until a new load starts.
REQ-024 In LOAD, a submit edge with word_count>0 SHALL enter RUN; cpu_reset falls and cpu_run rises in the cycle after the edge.
REQ-025 In LOAD, a submit edge with word_count=0 SHALL be ignored.
REQ-026 Coincident enter and submit edges in LOAD:
- The write is performed first.
- submit is held pending and takes effect on the cycle after WRITE, entering RUN because word_count is then >0.
- If full is high, overflow is set and submit proceeds immediately.
REQ-027 In RUN, enter edges and did_change SHALL be ignored; the shadow word is not updated.
REQ-028 In RUN, a submit edge SHALL start a new load in the next cycle:
- state=LOAD, cpu_reset=1, address=0, word_count=0, shadow=0, overflow=0, full=0.
- Memory contents are not cleared.
REQ-029 did_change high in the same cycle as an enter edge SHALL update the shadow word before it is committed; the shadow register is bypassed so the new data is written.

Reset
REQ-030 While reset is high at a clock edge, the block SHALL set:
- state=LOAD, mem_wr_en=0, mem_addr=0, mem_wr_data=0, word_count=0;
- shadow=0, edge-detect registers=0, pending submit=0;
- cpu_reset=1, cpu_run=0, full=0, overflow=0.
REQ-031 Reset SHALL take priority over every event. A reset coinciding with WRITE SHALL suppress that write strobe.
REQ-032 Edges present in the first cycle after reset SHALL be detected against zeroed history, so an input already high at reset release counts as one event.

Verification
REQ-033 Digits then commit: did_change with data=0x2408000A, then data cleared to 0 with an enter pulse -> one strobe, mem_addr=0, mem_wr_data=0x2408000A, word_count=1.
REQ-034 Three commits then submit: word 0x1 written, word 0x2 written, word 0x3 written, then a submit pulse -> three strobes at addresses 0,1,2; cpu_reset falls the cycle after submit; word_count=3.
REQ-035 Fill with ADDR_W=2: four enters -> full=1, word_count=4; a fifth enter -> no strobe, overflow=1; submit -> RUN.
REQ-036 Submit from RUN, then one commit of 0xDEADBEEF -> cpu_reset=1; the write goes to mem_addr=0; word_count=1; overflow=0.
REQ-037 Corner events:
- Submit with word_count=0 -> state stays LOAD, cpu_reset=1.
- Coincident enter+submit -> one strobe, then cpu_run=1 one cycle after WRITE.
REQ-038 Reset asserted in the WRITE cycle -> mem_wr_en=0 that cycle, all outputs at reset values the next cycle.
